// File: rtl/eth_rx_frame_filter.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_frame_filter
// Description : Receive-side store-and-forward frame buffer. Frames from the
//               MAC are written speculatively, filtered on destination MAC,
//               length and error status, and either committed for the
//               downstream parser or discarded by rewinding the write pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_frame_filter #(
    parameter int ADDR_W = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] i_self_mac,
    input  logic        i_promisc,
    input  logic [31:0] i_mac_data,
    input  logic        i_mac_vld,
    input  logic        i_mac_sop,
    input  logic        i_mac_eop,
    input  logic        i_mac_err,
    output logic [31:0] o_rx_data,
    output logic        o_rx_vld,
    output logic        o_rx_sop,
    output logic        o_rx_eop,
    input  logic        i_rx_rdy,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_drop_cnt
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [47:0]       BCAST   = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR1 = 2'd1,
        S_BODY = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ADDR_W-1:0] cm_ptr;
    logic [ADDR_W-1:0] cm_ptr_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [31:0]       dst_hi;
    logic              dst_hi_ld;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic              good_inc;
    logic [1:0]        drop_inc;

    // Word storage: {data, sop, eop}
    logic [33:0]       mem [DEPTH];

    logic              full;
    logic              start_full;
    logic [47:0]       dst;
    logic              match;
    logic              rd_avail;
    logic              rd_en;

    // A new frame always starts at cm_ptr, so its fullness is judged from there
    assign full       = (wr_ptr + PTR_ONE) == rd_ptr;
    assign start_full = (cm_ptr + PTR_ONE) == rd_ptr;
    assign dst        = {dst_hi, i_mac_data[31:16]};
    assign match      = i_promisc || (dst == i_self_mac) || (dst == BCAST);
    assign rd_avail   = rd_ptr != cm_ptr;
    assign rd_en      = rd_avail && (!o_rx_vld || i_rx_rdy);

    // Write-side next state: frame acceptance, filtering and rewind decisions
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        cm_ptr_nxt = cm_ptr;
        mem_we     = 1'b0;
        mem_waddr  = wr_ptr;
        dst_hi_ld  = 1'b0;
        good_inc   = 1'b0;
        drop_inc   = 2'd0;
        if (i_mac_vld) begin
            if (i_mac_sop && (state != S_DROP)) begin
                // A sop mid-frame abandons the frame in progress
                if (state != S_IDLE) begin
                    drop_inc = 2'd1;
                end
                if (i_mac_eop) begin
                    drop_inc   = drop_inc + 2'd1;
                    wr_ptr_nxt = cm_ptr;
                    state_nxt  = S_IDLE;
                end else if (start_full) begin
                    drop_inc   = drop_inc + 2'd1;
                    wr_ptr_nxt = cm_ptr;
                    state_nxt  = S_DROP;
                end else begin
                    mem_we     = 1'b1;
                    mem_waddr  = cm_ptr;
                    wr_ptr_nxt = cm_ptr + PTR_ONE;
                    dst_hi_ld  = 1'b1;
                    state_nxt  = S_HDR1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        state_nxt = S_IDLE;
                    end
                    S_HDR1: begin
                        if (full || i_mac_eop || !match) begin
                            drop_inc   = 2'd1;
                            wr_ptr_nxt = cm_ptr;
                            state_nxt  = i_mac_eop ? S_IDLE : S_DROP;
                        end else begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + PTR_ONE;
                            state_nxt  = S_BODY;
                        end
                    end
                    S_BODY: begin
                        if (full || (i_mac_eop && i_mac_err)) begin
                            drop_inc   = 2'd1;
                            wr_ptr_nxt = cm_ptr;
                            state_nxt  = i_mac_eop ? S_IDLE : S_DROP;
                        end else begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + PTR_ONE;
                            if (i_mac_eop) begin
                                cm_ptr_nxt = wr_ptr + PTR_ONE;
                                good_inc   = 1'b1;
                                state_nxt  = S_IDLE;
                            end
                        end
                    end
                    S_DROP: begin
                        if (i_mac_eop) begin
                            state_nxt = S_IDLE;
                        end
                    end
                    default: begin
                        state_nxt = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Write-side state, pointers, captured destination and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            cm_ptr     <= '0;
            dst_hi     <= '0;
            o_good_cnt <= '0;
            o_drop_cnt <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            cm_ptr     <= cm_ptr_nxt;
            if (dst_hi_ld) begin
                dst_hi <= i_mac_data;
            end
            o_good_cnt <= o_good_cnt + {15'd0, good_inc};
            o_drop_cnt <= o_drop_cnt + {14'd0, drop_inc};
        end
    end

    // Buffer write port
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= {i_mac_data, i_mac_sop, i_mac_eop};
        end
    end

    // Read side: registered RAM read straight into the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            o_rx_vld  <= 1'b0;
            o_rx_data <= '0;
            o_rx_sop  <= 1'b0;
            o_rx_eop  <= 1'b0;
        end else if (rd_en) begin
            {o_rx_data, o_rx_sop, o_rx_eop} <= mem[rd_ptr];
            o_rx_vld <= 1'b1;
            rd_ptr   <= rd_ptr + PTR_ONE;
        end else if (i_rx_rdy) begin
            o_rx_vld <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/eth_rx_frame_filter.md
# eth_rx_frame_filter

Receive-side store-and-forward frame buffer between the MAC RX stream and the packet-type parser. Each incoming 32-bit frame is written speculatively into an internal buffer; the destination MAC is checked against the station address (or broadcast), and at end of frame the frame is either committed for output or discarded by rewinding the write pointer. Only complete, error-free, address-matching frames reach the downstream parser, which may apply backpressure freely.

## Interface
- ADDR_W, 9, buffer depth 2^ADDR_W words of {data[31:0], sop, eop}; usable capacity 2^ADDR_W-1 words
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_self_mac  in  48  station MAC, byte 0 in bits [47:40]
- i_promisc  in  1  1 = skip MAC check (error/overflow checks still apply)
- i_mac_data  in  32  MAC RX word, first byte on the wire in [31:24]
- i_mac_vld  in  1  word valid; no backpressure toward MAC
- i_mac_sop  in  1  first word of frame
- i_mac_eop  in  1  last word of frame
- i_mac_err  in  1  frame error (CRC/PHY), meaningful on eop word
- o_rx_data  out  32  output word
- o_rx_vld  out  1  output word valid
- o_rx_sop  out  1  first word of frame
- o_rx_eop  out  1  last word of frame
- i_rx_rdy  in  1  downstream accepts word
- o_good_cnt  out  16  committed-frame counter, wraps 0xFFFF->0
- o_drop_cnt  out  16  dropped-frame counter, wraps 0xFFFF->0

## Operation
- Pointers: wr_ptr (speculative), cm_ptr (committed), rd_ptr; ADDR_W bits, natural wrap. Full when wr_ptr+1 == rd_ptr.
- Write FSM, evaluated on i_mac_vld cycles:
  - IDLE: sop word -> write at wr_ptr, capture word0 as dst[47:16], go HDR1. Non-sop words ignored.
  - HDR1: word1[31:16] completes dst; match = promisc | dst==i_self_mac | dst==48'hFFFF_FFFF_FFFF. Write word; match & ~eop -> BODY; no match -> DROP; eop -> drop frame (runt), IDLE.
  - BODY: write words. On eop: if ~i_mac_err commit (cm_ptr <= wr_ptr+1, good_cnt+1) else rewind (wr_ptr <= cm_ptr, drop_cnt+1); go IDLE.
  - DROP: rewind wr_ptr <= cm_ptr on entry, drop_cnt+1 once; ignore words until eop, then IDLE.
- Drop causes: err on eop, MAC mismatch, runt (sop&eop same word, or eop on word1), overflow (word arrives while full -> DROP), new sop while in HDR1/BODY (current frame dropped, new frame starts in HDR1 from that word; drop counted once).
- Simultaneous eop & err on same word -> drop. eop on a full-buffer word -> drop.
- Read side: words available when rd_ptr != cm_ptr; only whole committed frames are ever readable. Registered RAM read plus one output register; skid-free prefetch so a word is presented whenever available and the output register is empty or being consumed.
- Contents delivered bit-exact, same order, sop/eop flags as stored.

## Timing
- Reset: o_rx_vld/sop/eop=0, o_rx_data=0, counters=0, all pointers 0, FSM IDLE.
- Counters update in the cycle after the deciding word.
- Latency: eop of good frame written in cycle E -> first output word (o_rx_sop=1) valid in cycle E+2 when buffer otherwise empty and i_rx_rdy=1.
- Output handshake: transfer on o_rx_vld & i_rx_rdy; while o_rx_vld & ~i_rx_rdy, data/sop/eop held stable. Throughput 1 word/cycle with i_rx_rdy held high.
- Commit and read in same cycle permitted; read never passes cm_ptr.
- Rewind and read in same cycle: rewind affects only wr_ptr; output unaffected.
- Reset mid-frame: partial frames and buffered data discarded; output deasserts asynchronously.

## Test plan
- self_mac=02:00:00:00:00:01, 16-word frame dst match, rdy=1 -> identical 16 words out, sop word0, eop word15, o_rx_sop at E+2, good_cnt=1.
- Broadcast frame then dst 02:00:00:00:00:02 frame -> first output, second absent; good_cnt=1, drop_cnt=1; with i_promisc=1 both output.
- 10-word matching frame with err on eop, then 6-word good frame -> only 6-word frame out, intact; drop_cnt=1.
- ADDR_W=4, i_rx_rdy=0, 20-word frame -> dropped (drop_cnt=1), no output; then 8-word frame -> output after rdy=1.
- sop inside BODY, sop&eop runt, and back-to-back frames with i_rx_rdy toggling 1/0 -> drops counted (2), good frames in order, data stable while stalled.
- rst_n low mid-frame and mid-output -> all outputs 0 immediately; after release next good frame output correctly, counters from 0.
